// File: rtl/fetch_exec_ctrl_if.sv
// fetch_exec_ctrl_if
// Bundles the sequencer's connections to the instruction register, the
// register file and the ALU.
//   master : the sequencer (fetch_exec_ctrl)
//   slave  : the datapath side (inst_reg / registers / alu)
// Signals:
//   start      : begin execution from PC 0 (to master)
//   pc, ir_en  : instruction address and IR enable (from master)
//   ir_data    : 16-bit instruction, valid while ir_en is high (to master)
//   rf_addr, rf_rd, rf_wr, rf_wdata : register file access (from master)
//   rf_rdata   : combinational read data (to master)
//   alu_opcode, alu_a, alu_b : ALU controls/operands (from master)
//   alu_out    : combinational ALU result (to master)
//   busy, halted, instr_done : status (from master)
//   step       : single-step release, only when CTRL_SINGLE_STEP_EN is defined
interface fetch_exec_ctrl_if #(
  parameter int PC_W   = 2,
  parameter int DATA_W = 8
);
  logic              start;
  logic [PC_W-1:0]   pc;
  logic              ir_en;
  logic [15:0]       ir_data;
  logic [1:0]        rf_addr;
  logic              rf_rd;
  logic              rf_wr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata;
  logic [2:0]        alu_opcode;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_out;
  logic              busy;
  logic              halted;
  logic              instr_done;
`ifdef CTRL_SINGLE_STEP_EN
  logic              step;
`endif

  modport master (
    input  start, ir_data, rf_rdata, alu_out,
`ifdef CTRL_SINGLE_STEP_EN
    input  step,
`endif
    output pc, ir_en, rf_addr, rf_rd, rf_wr, rf_wdata,
    output alu_opcode, alu_a, alu_b, busy, halted, instr_done
  );

  modport slave (
    output start, ir_data, rf_rdata, alu_out,
`ifdef CTRL_SINGLE_STEP_EN
    output step,
`endif
    input  pc, ir_en, rf_addr, rf_rd, rf_wr, rf_wdata,
    input  alu_opcode, alu_a, alu_b, busy, halted, instr_done
  );
endinterface

// File: rtl/fetch_exec_ctrl.sv
// fetch_exec_ctrl
// Fetch/decode/execute sequencer. Fetches a 16-bit instruction through the
// instruction register, decodes it and runs the register-file read, ALU and
// write-back cycles. Instructions: LDI (1000), HALT (1001), ALU (0xxx);
// any other encoding retires as a NOP.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fetch_exec_ctrl_if.master (see interface file for signal list)
// Optional build macro CTRL_SINGLE_STEP_EN: adds bus.step and a PAUSE state
// entered after every retired instruction; step=1 releases it to FETCH.
// All outputs are registered: each transition loads the output values
// belonging to the state being entered.
module fetch_exec_ctrl #(
  parameter int PC_W   = 2,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_exec_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WB_IMM, S_RD_A, S_RD_B, S_EXEC, S_WB_ALU,
    S_HALTED
`ifdef CTRL_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  function automatic logic is_ldi(input logic [15:0] ir);
    return ir[15:12] == 4'b1000;
  endfunction

  function automatic logic is_halt(input logic [15:0] ir);
    return ir[15:12] == 4'b1001;
  endfunction

  function automatic logic is_illegal(input logic [15:0] ir);
    return ir[15] && !is_ldi(ir) && !is_halt(ir);
  endfunction

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic              ir_en_q, ir_en_d;
  logic              rf_rd_q, rf_rd_d;
  logic              rf_wr_q, rf_wr_d;
  logic [1:0]        rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;   // also holds the ALU result
  logic [2:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;         // doubles as operand B register
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              done_q, done_d;
  logic              retire;

  // ir[11:10] carry no meaning in any encoding.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir_q[11:10];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    opa_d      = opa_q;
    ir_en_d    = 1'b0;
    rf_rd_d    = 1'b0;
    rf_wr_d    = 1'b0;
    done_d     = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_wdata_d = rf_wdata_q;
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    retire     = 1'b0;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (bus.start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          ir_en_d = 1'b1;
        end
      end
      S_FETCH: begin
        ir_d    = bus.ir_data;
        state_d = S_DECODE;
        // An illegal op retires in DECODE, so its pulse is loaded now.
        done_d  = is_illegal(bus.ir_data);
      end
      S_DECODE: begin
        if (is_ldi(ir_q)) begin
          state_d    = S_WB_IMM;
          rf_wr_d    = 1'b1;
          rf_addr_d  = ir_q[9:8];
          rf_wdata_d = DATA_W'(ir_q[7:0]);
          done_d     = 1'b1;
        end else if (is_halt(ir_q)) begin
          state_d = S_HALTED;
        end else if (!ir_q[15]) begin
          state_d   = S_RD_A;
          rf_rd_d   = 1'b1;
          rf_addr_d = ir_q[5:4];
        end else begin
          pc_d   = pc_q + PC_W'(1);
          retire = 1'b1;
        end
      end
      S_RD_A: begin
        opa_d     = bus.rf_rdata;
        state_d   = S_RD_B;
        rf_rd_d   = 1'b1;
        rf_addr_d = ir_q[1:0];
      end
      S_RD_B: begin
        // Operand B goes straight into the ALU operand register.
        state_d  = S_EXEC;
        alu_op_d = ir_q[15:13];
        alu_a_d  = opa_q;
        alu_b_d  = bus.rf_rdata;
      end
      S_EXEC: begin
        state_d    = S_WB_ALU;
        rf_wr_d    = 1'b1;
        rf_addr_d  = ir_q[9:8];
        rf_wdata_d = bus.alu_out;
        done_d     = 1'b1;
      end
      S_WB_IMM, S_WB_ALU: begin
        pc_d   = pc_q + PC_W'(1);
        retire = 1'b1;
      end
`ifdef CTRL_SINGLE_STEP_EN
      S_PAUSE: begin
        if (bus.step) begin
          state_d = S_FETCH;
          ir_en_d = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (retire) begin
`ifdef CTRL_SINGLE_STEP_EN
      state_d = S_PAUSE;
`else
      state_d = S_FETCH;
      ir_en_d = 1'b1;
`endif
    end

    busy_d   = !(state_d == S_IDLE || state_d == S_HALTED);
    halted_d = (state_d == S_HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      opa_q      <= '0;
      ir_en_q    <= 1'b0;
      rf_rd_q    <= 1'b0;
      rf_wr_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      opa_q      <= opa_d;
      ir_en_q    <= ir_en_d;
      rf_rd_q    <= rf_rd_d;
      rf_wr_q    <= rf_wr_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
      done_q     <= done_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.ir_en      = ir_en_q;
  assign bus.rf_addr    = rf_addr_q;
  assign bus.rf_rd      = rf_rd_q;
  assign bus.rf_wr      = rf_wr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.alu_opcode = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.busy       = busy_q;
  assign bus.halted     = halted_q;
  assign bus.instr_done = done_q;

endmodule

// File: doc/fetch_exec_ctrl.md
Name: fetch_exec_ctrl

Overview:
- Sequencer between the instruction register and the execute datapath: alu, registers, inst_reg.
- Drives the PC and instruction-register enable, then decodes the captured 16-bit instruction.
- Runs the register-file read/write and ALU cycles as a hardware FSM.
- Supports load-immediate, 2-source ALU ops and halt.

Parameters:
PC_W, 2, program counter width; PC wraps modulo 2^PC_W
DATA_W, 8, register/ALU data width (instruction field layout assumes 8)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin execution from PC 0 (sampled in IDLE or HALTED)
pc  output  PC_W  instruction address to inst_reg
ir_en  output  1  instruction register enable
ir_data  input  16  instruction from inst_reg, valid same cycle as ir_en
rf_addr  output  2  register file address
rf_rd  output  1  register file read strobe
rf_wr  output  1  register file write strobe
rf_wdata  output  DATA_W  register write data
rf_rdata  input  DATA_W  register read data, combinational from rf_addr/rf_rd
alu_opcode  output  3  ALU operation select
alu_a  output  DATA_W  ALU operand A
alu_b  output  DATA_W  ALU operand B
alu_out  input  DATA_W  ALU result, combinational
busy  output  1  high in any state except IDLE/HALTED
halted  output  1  high in HALTED
instr_done  output  1  1-cycle pulse in final cycle of each retired instruction

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=0, ir_q=0, opA=opB=res=0.
  - All strobes low; alu_opcode=0; busy=halted=instr_done=0.
  - Reset mid-instruction aborts it immediately; no pending write completes.
- Decode on captured ir_q:
  - ir[15:12]=1000 LDI: rd=ir[9:8], imm=ir[7:0].
  - ir[15:12]=1001 HALT.
  - ir[15]=0 ALU: alu_opcode=ir[15:13], rd=ir[9:8], rsA=ir[5:4], rsB=ir[1:0].
  - Any other encoding: illegal, executes as NOP.
- States and per-state outputs:
  - IDLE: start=1 -> FETCH, pc=0.
  - FETCH: ir_en=1; ir_data latched to ir_q at edge; -> DECODE.
  - DECODE:
    - LDI -> WB_IMM.
    - ALU -> RD_A.
    - HALT -> HALTED; pc not incremented.
    - Illegal: instr_done=1, pc+1, -> FETCH.
  - WB_IMM: rf_wr=1, rf_addr=rd, rf_wdata=imm, instr_done=1; pc+1; -> FETCH.
  - RD_A: rf_rd=1, rf_addr=rsA; opA<=rf_rdata; -> RD_B.
  - RD_B: rf_rd=1, rf_addr=rsB; opB<=rf_rdata; -> EXEC.
  - EXEC: alu_opcode/alu_a=opA/alu_b=opB driven; res<=alu_out; -> WB_ALU.
  - WB_ALU: rf_wr=1, rf_addr=rd, rf_wdata=res, instr_done=1; pc+1; -> FETCH.
  - HALTED: halted=1; start=1 -> FETCH with pc=0.
- Output hold rules:
  - alu_a/alu_b/alu_opcode hold their last values outside EXEC.
  - rf_rd, rf_wr, ir_en are never high simultaneously.
- Latency from FETCH entry: LDI 3 cycles, ALU 6 cycles, illegal 2 cycles; HALTED is reached after 2 cycles.
- PC arithmetic: increment modulo 2^PC_W (PC_W=2: 3 -> 0). No halt on wrap.
- start while busy is ignored.
- Register hazards: rsA=rsB=rd is legal; reads precede the write, so old values are used.

Optional Feature:
- Macro: CTRL_SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit) and state PAUSE.
  - Every state that asserts instr_done goes to PAUSE instead of FETCH.
  - PAUSE: busy=1, no strobes; step=1 -> FETCH.
  - step is ignored in all other states.
- Not defined: no step port, no PAUSE state; retirement goes straight to FETCH.

Test Plan:
- Reset mid-op: assert rst_n=0 during RD_B of an ALU op -> next cycle pc=0, busy=0, rf_wr never pulses for that instruction.
- LDI retire: start with ir_data=0x8105 -> 3rd cycle rf_wr=1, rf_addr=1, rf_wdata=0x05, instr_done=1; pc becomes 1.
- ALU op: ir_data=0x0201, rf_rdata model r0=3/r1=5, alu_out model A+B:
  - RD_A has rf_addr=0, RD_B has rf_addr=1.
  - EXEC has alu_opcode=0, alu_a=3, alu_b=5.
  - WB_ALU has rf_addr=2, rf_wdata=8, on 6th cycle.
- Halt then restart: ir_data=0x9000 at pc=2 -> halted=1, pc stays 2; start pulse -> FETCH with pc=0.
- PC wrap and illegal opcode: four illegal instructions (0xF000) -> instr_done every 2 cycles, pc sequence 0,1,2,3,0, no rf strobes.
- Single step (macro on): LDI retires -> state PAUSE, busy=1, pc stable for 10 cycles; step=1 -> FETCH next cycle.
